dm_responder: RTL and testbench

//   Data-memory responder for the MEM stage of the 5-stage pipeline; replaces the

---
 rtl/dm_responder.sv | 110 +++++++++++
 tb/tb_dm_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// MEM-stage data memory slave: one load/store at a time with configurable
// response latency, byte-enabled stores and saturating access counters.
module dm_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              stall,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT =
    (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  if (LATENCY < 1 || LATENCY > 15) begin : g_lat_chk
    $error("dm_responder: LATENCY must be within 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic [31:0]         mem [0:DEPTH-1];

  assign stall = req_valid & ~resp_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      be_q       <= 4'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      rd_count   <= 16'h0;
      wr_count   <= 16'h0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            if (LATENCY == 1) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= req_we ? 32'h0 : mem[req_addr];
            end else begin
              cnt   <= CNT_INIT;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= we_q ? 32'h0 : mem[addr_q];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          if (we_q) begin
            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
          end else begin
            if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
          end
        end
        default: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

  // The store lands on the edge that ends the response cycle.
  always_ff @(posedge clk) begin
    if (state == S_RESP && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: latency 2 instance for most steps,
// latency 1 instance for back-to-back accepts.
module tb_dm_responder;

  logic        clk;
  logic        rst;

  logic        req_valid;
  logic        req_we;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        stall;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  logic        r1_valid;
  logic        r1_we;
  logic [9:0]  r1_addr;
  logic [31:0] r1_wdata;
  logic [3:0]  r1_be;
  logic        r1_resp_valid;
  logic [31:0] r1_rdata;
  logic        r1_stall;
  logic [15:0] r1_rd_count;
  logic [15:0] r1_wr_count;

  int n_tests;
  int n_fail;
  logic [31:0] rd;

  dm_responder #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .stall      (stall),
    .rd_count   (rd_count),
    .wr_count   (wr_count)
  );

  dm_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (r1_valid),
    .req_we     (r1_we),
    .req_addr   (r1_addr),
    .req_wdata  (r1_wdata),
    .req_be     (r1_be),
    .resp_valid (r1_resp_valid),
    .resp_rdata (r1_rdata),
    .stall      (r1_stall),
    .rd_count   (r1_rd_count),
    .wr_count   (r1_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] data);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    tick();
    n = 0;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("resp_timeout", {31'h0, resp_valid}, 32'h1);
    data = resp_rdata;
    req_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    r1_valid  = 1'b0;
    r1_we     = 1'b0;
    r1_addr   = '0;
    r1_wdata  = '0;
    r1_be     = '0;
    tick();
    tick();
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_rd_count", {16'h0, rd_count}, 32'h0);
    chk("rst_wr_count", {16'h0, wr_count}, 32'h0);
    rst = 1'b1;
    tick();

    // store addr 5, exact latency 2
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 10'd5;
    req_wdata = 32'hDEADBEEF;
    req_be    = 4'hF;
    #1;
    chk("st_acc_stall", {31'h0, stall}, 32'h1);
    chk("st_acc_resp", {31'h0, resp_valid}, 32'h0);
    tick();
    chk("st_wait_stall", {31'h0, stall}, 32'h1);
    chk("st_wait_resp", {31'h0, resp_valid}, 32'h0);
    tick();
    chk("st_resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("st_resp_stall", {31'h0, stall}, 32'h0);
    chk("st_resp_rdata", resp_rdata, 32'h0);
    req_valid = 1'b0;
    tick();
    chk("st_resp_pulse", {31'h0, resp_valid}, 32'h0);
    chk("st_wr_count", {16'h0, wr_count}, 32'h1);

    do_req(1'b0, 10'd5, 32'h0, 4'h0, rd);
    chk("ld5_data", rd, 32'hDEADBEEF);
    chk("ld5_rd_count", {16'h0, rd_count}, 32'h1);
    chk("ld5_wr_count", {16'h0, wr_count}, 32'h1);

    // byte enables
    do_req(1'b1, 10'd9, 32'h11223344, 4'hF, rd);
    do_req(1'b1, 10'd9, 32'hAABBCCDD, 4'b0101, rd);
    do_req(1'b0, 10'd9, 32'h0, 4'h0, rd);
    chk("be_merge", rd, 32'h11BB33DD);
    chk("be_wr_count", {16'h0, wr_count}, 32'h3);

    // req_valid dropped during WAIT
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 10'd7;
    req_wdata = 32'h12345678;
    req_be    = 4'hF;
    tick();
    req_valid = 1'b0;
    req_wdata = 32'hFFFFFFFF;
    req_addr  = 10'd8;
    #1;
    chk("drop_wait_stall", {31'h0, stall}, 32'h0);
    tick();
    chk("drop_resp_valid", {31'h0, resp_valid}, 32'h1);
    tick();
    chk("drop_wr_count", {16'h0, wr_count}, 32'h4);
    do_req(1'b0, 10'd7, 32'h0, 4'h0, rd);
    chk("drop_mem7", rd, 32'h12345678);

    // reset during RESP
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 10'd5;
    tick();
    tick();
    chk("rr_resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("rr_rdata", resp_rdata, 32'hDEADBEEF);
    req_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("rr_async_resp", {31'h0, resp_valid}, 32'h0);
    chk("rr_async_rdata", resp_rdata, 32'h0);
    chk("rr_async_rd", {16'h0, rd_count}, 32'h0);
    chk("rr_async_wr", {16'h0, wr_count}, 32'h0);
    chk("rr_async_stall", {31'h0, stall}, 32'h0);
    rst = 1'b1;
    tick();

    // reset during WAIT aborts the store
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 10'd5;
    req_wdata = 32'h0;
    req_be    = 4'hF;
    tick();
    req_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    tick();
    chk("abort_no_resp", {31'h0, resp_valid}, 32'h0);
    do_req(1'b0, 10'd5, 32'h0, 4'h0, rd);
    chk("abort_mem5", rd, 32'hDEADBEEF);
    chk("abort_wr_count", {16'h0, wr_count}, 32'h0);
    chk("abort_rd_count", {16'h0, rd_count}, 32'h1);

    // latency 1, back-to-back loads held valid
    r1_valid = 1'b1;
    r1_we    = 1'b0;
    r1_addr  = 10'd3;
    #1;
    chk("l1_c0_stall", {31'h0, r1_stall}, 32'h1);
    chk("l1_c0_resp", {31'h0, r1_resp_valid}, 32'h0);
    tick();
    chk("l1_c1_resp", {31'h0, r1_resp_valid}, 32'h1);
    chk("l1_c1_stall", {31'h0, r1_stall}, 32'h0);
    tick();
    chk("l1_c2_resp", {31'h0, r1_resp_valid}, 32'h0);
    chk("l1_c2_stall", {31'h0, r1_stall}, 32'h1);
    tick();
    chk("l1_c3_resp", {31'h0, r1_resp_valid}, 32'h1);
    chk("l1_c3_stall", {31'h0, r1_stall}, 32'h0);
    r1_valid = 1'b0;
    tick();
    chk("l1_rd_count", {16'h0, r1_rd_count}, 32'h2);

    // saturation from a preset count
    force dut.rd_count = 16'hFFFE;
    #1;
    release dut.rd_count;
    #1;
    chk("sat_preset", {16'h0, rd_count}, 32'h0000FFFE);
    do_req(1'b0, 10'd5, 32'h0, 4'h0, rd);
    chk("sat_ld1", {16'h0, rd_count}, 32'h0000FFFF);
    do_req(1'b0, 10'd5, 32'h0, 4'h0, rd);
    chk("sat_ld2", {16'h0, rd_count}, 32'h0000FFFF);
    do_req(1'b0, 10'd5, 32'h0, 4'h0, rd);
    chk("sat_ld3", {16'h0, rd_count}, 32'h0000FFFF);
    chk("sat_wr_count", {16'h0, wr_count}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
